addsub_pipe: RTL and testbench

ADDSUB_PIPE -- requirements
Module: addsub_pipe

---
 rtl/addsub_pipe_if.sv | 34 +++
 rtl/addsub_pipe.sv | 154 +++++++++++++++
 tb/tb_addsub_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// The slave side is the adder; the master side is the producer and consumer.
interface addsub_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sub;
    logic             Signed;
    logic [TAGW-1:0]  InTag;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] S;
    logic             Zero;
    logic             Overflow;
    logic             Negative;
    logic             Carry;
    logic [TAGW-1:0]  OutTag;
    logic             StickyOverflow;
    logic             ClearSticky;

    modport slave (
        input  InValid, A, B, Sub, Signed, InTag, OutReady, ClearSticky,
        output InReady, OutValid, S, Zero, Overflow, Negative, Carry, OutTag, StickyOverflow
    );

    modport master (
        output InValid, A, B, Sub, Signed, InTag, OutReady, ClearSticky,
        input  InReady, OutValid, S, Zero, Overflow, Negative, Carry, OutTag, StickyOverflow
    );
endinterface

// File: rtl/addsub_pipe.sv
// Two-stage add/subtract pipeline with valid/ready flow control and result flags.
// Stage 1 sums the low half; stage 2 finishes the high half and registers the flags.
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
) (
    input  logic         clk,
    input  logic         reset,
    addsub_pipe_if.slave bus
);
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    logic             s1_vld_q, s1_vld_d;
    logic [LO-1:0]    s1_lo_q, s1_lo_d;
    logic             s1_c_q, s1_c_d;
    logic [HI-1:0]    s1_ah_q, s1_ah_d;
    logic [HI-1:0]    s1_bh_q, s1_bh_d;
    logic             s1_sub_q, s1_sub_d;
    logic             s1_sgn_q, s1_sgn_d;
    logic [TAGW-1:0]  s1_tag_q, s1_tag_d;

    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic             sticky_q, sticky_d;

    logic             s1_ld, s2_ld, in_xfer, out_xfer;
    logic [WIDTH-1:0] b_p;
    logic [LO:0]      lo_sum;
    logic [HI:0]      hi_sum;
    logic [WIDTH-1:0] sum_w;
    logic             a_msb, b_msb, s_msb, c_out, ovf_w, neg_w;

    always_comb begin
        s2_ld    = ~s2_vld_q | bus.OutReady;
        s1_ld    = ~s1_vld_q | s2_ld;
        in_xfer  = bus.InValid & s1_ld;
        out_xfer = s2_vld_q & bus.OutReady;

        // Subtraction is A + ~B + 1, the +1 entering as the low-half carry-in.
        b_p    = bus.Sub ? ~bus.B : bus.B;
        lo_sum = {1'b0, bus.A[LO-1:0]} + {1'b0, b_p[LO-1:0]} + {{LO{1'b0}}, bus.Sub};

        s1_vld_d = s1_vld_q;
        s1_lo_d  = s1_lo_q;
        s1_c_d   = s1_c_q;
        s1_ah_d  = s1_ah_q;
        s1_bh_d  = s1_bh_q;
        s1_sub_d = s1_sub_q;
        s1_sgn_d = s1_sgn_q;
        s1_tag_d = s1_tag_q;
        if (s1_ld) s1_vld_d = in_xfer;
        if (in_xfer) begin
            s1_lo_d  = lo_sum[LO-1:0];
            s1_c_d   = lo_sum[LO];
            s1_ah_d  = bus.A[WIDTH-1:LO];
            s1_bh_d  = b_p[WIDTH-1:LO];
            s1_sub_d = bus.Sub;
            s1_sgn_d = bus.Signed;
            s1_tag_d = bus.InTag;
        end
    end

    always_comb begin
        hi_sum = {1'b0, s1_ah_q} + {1'b0, s1_bh_q} + {{HI{1'b0}}, s1_c_q};
        sum_w  = {hi_sum[HI-1:0], s1_lo_q};
        c_out  = hi_sum[HI];
        a_msb  = s1_ah_q[HI-1];
        // b_msb is the msb of the effective addend, so "A and B' agree" covers add and sub alike.
        b_msb  = s1_bh_q[HI-1];
        s_msb  = sum_w[WIDTH-1];
        if (s1_sgn_q) begin
            ovf_w = (a_msb == b_msb) & (s_msb != a_msb);
            neg_w = (a_msb == b_msb) ? a_msb : s_msb;
        end else begin
            ovf_w = s1_sub_q ? ~c_out : c_out;
            neg_w = s1_sub_q & ~c_out;
        end

        s2_vld_d = s2_vld_q;
        s_d      = s_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        tag_d    = tag_q;
        if (s2_ld) s2_vld_d = s1_vld_q;
        if (s2_ld && s1_vld_q) begin
            s_d     = sum_w;
            zero_d  = (sum_w == '0) & ~ovf_w;
            ovf_d   = ovf_w;
            neg_d   = neg_w;
            carry_d = c_out;
            tag_d   = s1_tag_q;
        end

        sticky_d = sticky_q;
        if (out_xfer && ovf_q) sticky_d = 1'b1;
        else if (bus.ClearSticky) sticky_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q <= 1'b0;
            s1_lo_q  <= '0;
            s1_c_q   <= 1'b0;
            s1_ah_q  <= '0;
            s1_bh_q  <= '0;
            s1_sub_q <= 1'b0;
            s1_sgn_q <= 1'b0;
            s1_tag_q <= '0;
            s2_vld_q <= 1'b0;
            s_q      <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            tag_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_lo_q  <= s1_lo_d;
            s1_c_q   <= s1_c_d;
            s1_ah_q  <= s1_ah_d;
            s1_bh_q  <= s1_bh_d;
            s1_sub_q <= s1_sub_d;
            s1_sgn_q <= s1_sgn_d;
            s1_tag_q <= s1_tag_d;
            s2_vld_q <= s2_vld_d;
            s_q      <= s_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            tag_q    <= tag_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.InReady        = s1_ld;
    assign bus.OutValid       = s2_vld_q;
    assign bus.S              = s_q;
    assign bus.Zero           = zero_q;
    assign bus.Overflow       = ovf_q;
    assign bus.Negative       = neg_q;
    assign bus.Carry          = carry_q;
    assign bus.OutTag         = tag_q;
    assign bus.StickyOverflow = sticky_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: arithmetic reference model with an in-order result queue,
// a per-cycle compare process, and directed vectors with literal expectations.
module tb_addsub_pipe;
    localparam int WIDTH = 32;
    localparam int TAGW  = 4;

    typedef struct {
        logic [31:0] s;
        logic        z, o, n, c;
        logic [3:0]  tag;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();
    addsub_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    logic m_sticky = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference computed from true integer values, not from a half-split adder.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic sgn, input logic [3:0] tag);
        res_t r;
        longint sa, sb, sr;
        longint unsigned ua, ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        r.s = sub ? a - b : a + b;
        r.c = sub ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
        if (sgn) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            sr  = sub ? sa - sb : sa + sb;
            r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            r.n = sr < 0;
        end else begin
            r.o = sub ? (ua < ub) : ((ua + ub) >= 64'h1_0000_0000);
            r.n = sub && (ua < ub);
        end
        r.z   = (r.s == 32'd0) && !r.o;
        r.tag = tag;
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_sticky = 1'b0;
        end else begin
            logic in_x, out_x, ov;
            in_x  = bus.InValid & bus.InReady;
            out_x = bus.OutValid & bus.OutReady;
            ov    = 1'b0;
            if (out_x && exp_q.size() > 0) begin
                ov = exp_q[0].o;
                void'(exp_q.pop_front());
            end
            if (out_x && ov) m_sticky = 1'b1;
            else if (bus.ClearSticky) m_sticky = 1'b0;
            if (in_x) exp_q.push_back(model(bus.A, bus.B, bus.Sub, bus.Signed, bus.InTag));
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("m_inready", bus.InReady, (exp_q.size() < 2) || bus.OutReady);
            chk("m_sticky", bus.StickyOverflow, m_sticky);
            if (bus.OutValid) begin
                if (exp_q.size() == 0) begin
                    chk("m_spurious", bus.OutValid, 0);
                end else begin
                    chk("m_s", bus.S, exp_q[0].s);
                    chk("m_flags", {bus.Zero, bus.Overflow, bus.Negative, bus.Carry},
                        {exp_q[0].z, exp_q[0].o, exp_q[0].n, exp_q[0].c});
                    chk("m_tag", bus.OutTag, exp_q[0].tag);
                end
            end
        end
    end

    task automatic send_chk(input string nm, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic sgn, input logic [3:0] tag,
                            input logic [31:0] es, input logic ez, input logic eo,
                            input logic en, input logic ec);
        @(posedge clk); #1;
        bus.A = a; bus.B = b; bus.Sub = sub; bus.Signed = sgn; bus.InTag = tag;
        bus.InValid = 1'b1; bus.OutReady = 1'b1;
        @(negedge clk); chk({nm, "_inready"}, bus.InReady, 1);
        @(posedge clk); #1 bus.InValid = 1'b0;
        @(negedge clk); chk({nm, "_lat1"}, bus.OutValid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, bus.OutValid, 1);
        chk({nm, "_s"}, bus.S, es);
        chk({nm, "_zonc"}, {bus.Zero, bus.Overflow, bus.Negative, bus.Carry}, {ez, eo, en, ec});
        chk({nm, "_tag"}, bus.OutTag, tag);
    endtask

    logic [31:0] va [8] = '{32'h1234_5678, 32'h8000_0001, 32'h0000_FFFF, 32'h7FFF_0000,
                            32'hFFFF_0000, 32'h0000_0010, 32'hC000_0000, 32'h0001_0000};
    logic [31:0] vb [8] = '{32'h1111_1111, 32'h0000_0002, 32'h0000_FFFF, 32'h0001_0000,
                            32'h0001_0000, 32'h0000_0020, 32'h4000_0000, 32'h0000_0001};
    logic [7:0]  vsub = 8'b1010_1100;
    logic [7:0]  vsgn = 8'b0110_0101;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.InValid = 0; bus.A = 0; bus.B = 0; bus.Sub = 0; bus.Signed = 0; bus.InTag = 0;
        bus.OutReady = 0; bus.ClearSticky = 0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outvalid", bus.OutValid, 0);
        chk("rst_s", bus.S, 0);
        chk("rst_flags", {bus.Zero, bus.Overflow, bus.Negative, bus.Carry}, 0);
        chk("rst_tag", bus.OutTag, 0);
        chk("rst_sticky", bus.StickyOverflow, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); chk("rst_inready", bus.InReady, 1);

        send_chk("ssub_min",  32'h0000_0000, 32'h8000_0000, 1, 1, 4'd1, 32'h8000_0000, 0, 1, 0, 0);
        send_chk("usub_5_7",  32'd5,         32'd7,         1, 0, 4'd2, 32'hFFFF_FFFE, 0, 1, 1, 0);
        send_chk("uadd_wrap", 32'hFFFF_FFFF, 32'd1,         0, 0, 4'd3, 32'h0000_0000, 0, 1, 0, 1);
        send_chk("uadd_mid",  32'h0000_FFFF, 32'd1,         0, 0, 4'd4, 32'h0001_0000, 0, 0, 0, 0);
        send_chk("sadd_max",  32'h7FFF_FFFF, 32'd1,         0, 1, 4'd5, 32'h8000_0000, 0, 1, 0, 0);
        send_chk("sadd_zero", 32'hFFFF_FFFF, 32'd1,         0, 1, 4'd6, 32'h0000_0000, 1, 0, 0, 1);
        send_chk("ssub_neg",  32'd3,         32'd5,         1, 1, 4'd7, 32'hFFFF_FFFE, 0, 0, 1, 0);
        send_chk("usub_eq",   32'd7,         32'd7,         1, 0, 4'd8, 32'h0000_0000, 1, 0, 0, 1);
        send_chk("sadd_minm", 32'h8000_0000, 32'h8000_0000, 0, 1, 4'd9, 32'h0000_0000, 0, 1, 1, 1);

        // Back-to-back tags against a stalled consumer.
        @(posedge clk); #1;
        bus.OutReady = 0; bus.Sub = 0; bus.Signed = 0; bus.A = 32'd100;
        bus.B = 32'd1; bus.InTag = 4'd1; bus.InValid = 1;
        @(posedge clk); #1 bus.InTag = 4'd2; bus.B = 32'd2;
        @(negedge clk); chk("stall_v0", bus.OutValid, 0);
        @(posedge clk); #1 bus.InTag = 4'd3; bus.B = 32'd3;
        @(negedge clk);
        chk("stall_ready", bus.InReady, 0);
        chk("stall_tag", bus.OutTag, 1);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("stall_hold_v", bus.OutValid, 1);
            chk("stall_hold_tag", bus.OutTag, 1);
            chk("stall_hold_s", bus.S, 32'd101);
            chk("stall_hold_rdy", bus.InReady, 0);
        end
        @(posedge clk); #1 bus.OutReady = 1;
        @(negedge clk);
        chk("rel_ready", bus.InReady, 1);
        chk("rel_tag1", bus.OutTag, 1);
        @(posedge clk); #1 bus.InValid = 0;
        @(negedge clk); chk("rel_tag2", bus.OutTag, 2); chk("rel_s2", bus.S, 32'd102);
        @(posedge clk); @(negedge clk);
        chk("rel_v3", bus.OutValid, 1); chk("rel_tag3", bus.OutTag, 3); chk("rel_s3", bus.S, 32'd103);
        @(posedge clk); @(negedge clk); chk("rel_empty", bus.OutValid, 0);

        // Reset while two transactions are in flight.
        @(posedge clk); #1;
        bus.OutReady = 0; bus.A = 32'd1; bus.B = 32'd2; bus.InTag = 4'd5; bus.InValid = 1;
        @(posedge clk); #1 bus.InTag = 4'd6;
        @(posedge clk); #1 bus.InValid = 0;
        @(negedge clk);
        chk("pre_rst_valid", bus.OutValid, 1);
        chk("pre_rst_sticky", bus.StickyOverflow, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valid", bus.OutValid, 0);
        chk("mid_rst_sticky", bus.StickyOverflow, 0);
        @(posedge clk); #1 reset = 1'b1; bus.OutReady = 1;
        @(negedge clk); chk("post_rst_ready", bus.InReady, 1);
        repeat (4) begin
            chk("post_rst_stale", bus.OutValid, 0);
            @(negedge clk);
        end

        // Overflow transferred while ClearSticky is held: set wins, then clear.
        @(posedge clk); #1;
        bus.ClearSticky = 1; bus.OutReady = 1; bus.Sub = 0; bus.Signed = 0;
        bus.A = 32'hFFFF_FFFF; bus.B = 32'd1; bus.InTag = 4'd7; bus.InValid = 1;
        @(posedge clk); #1 bus.InValid = 0;
        @(posedge clk);
        @(negedge clk); chk("stk_valid", bus.OutValid, 1); chk("stk_ovf", bus.Overflow, 1);
        @(posedge clk); @(negedge clk); chk("stk_set", bus.StickyOverflow, 1);
        @(posedge clk); @(negedge clk); chk("stk_clr", bus.StickyOverflow, 0);
        @(posedge clk); #1 bus.ClearSticky = 0;

        // Stream with an intermittent consumer; the compare process checks every result.
        begin
            int idx = 0;
            int cyc = 0;
            while (idx < 8 && cyc < 200) begin
                bus.A = va[idx]; bus.B = vb[idx]; bus.Sub = vsub[idx]; bus.Signed = vsgn[idx];
                bus.InTag = 4'(idx + 8); bus.InValid = 1; bus.OutReady = (cyc % 3) != 2;
                @(negedge clk);
                begin
                    logic acc;
                    acc = bus.InReady;
                    @(posedge clk); #1;
                    if (acc) idx++;
                end
                cyc++;
            end
            chk("stream_sent", idx, 8);
            bus.InValid = 0; bus.OutReady = 1;
            cyc = 0;
            while (exp_q.size() != 0 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("stream_drain", exp_q.size(), 0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
